imu_seq_ctrl: RTL and testbench

Sequences one IMU serial read frame and forwards the captured sample to the external display shift register.
- Sits between the GPIO pins (IMU enable, IMU serial data in, shift-register SDI/clock/latch) and the team logic gated by the Wishbone-wrapper `en` bit.
- Each frame: chip-select low, clock in DATA_W bits MSB-first, publish the sample, shift it out MSB-first, pulse the latch.

---
 rtl/imu_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_imu_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_seq_ctrl.sv
// imu_seq_ctrl: runs one IMU serial read frame (chip-select low, DATA_W bits
// clocked in MSB-first), publishes the sample, then shifts it MSB-first into
// the external display shift register and strobes its latch.
// Optional feature macro: IMU_CONT_EN -- while imu_enable_in stays high, frames
// repeat with GAP idle cycles between them instead of one frame per rising edge.
module imu_seq_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int GAP     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              imu_enable_in,
    input  logic              imu_sdo_in,
    output logic              imu_cs_n,
    output logic              imu_sclk,
    output logic              sr_sdi,
    output logic              sr_clk,
    output logic              sr_latch,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int HALF_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    // Reject parameter values the counters and shift registers are not sized for.
    if (DATA_W < 2 || DATA_W > 32 || CLK_DIV < 1 || GAP < 1) begin : g_param_check
        $error("imu_seq_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
`ifdef IMU_CONT_EN
        , ST_GAP
`endif
    } state_t;

    state_t              state, state_d;
    logic [DIV_W-1:0]    div_cnt, div_d;
    logic [HALF_W-1:0]   half_cnt, half_d;
    logic                sclk_d, srclk_d;
    logic                in_shift, out_shift, load_go;
    logic [2:0]          sync_q;
    logic [DATA_W-1:0]   in_shreg, out_shreg;

`ifdef IMU_CONT_EN
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    logic [GAP_W-1:0]    gap_cnt, gap_d;
`endif

    // sync_q[1] is the synchronized request; sync_q[2] is its previous value.
    wire enable_sync = sync_q[1];
    wire start_edge  = sync_q[1] & ~sync_q[2];
    wire half_done   = (div_cnt == DIV_LAST);

    // Two-flop synchronizer for the pad request plus one flop for edge detect.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], imu_enable_in};
    end

    // FSM state register and phase counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
`ifdef IMU_CONT_EN
            gap_cnt  <= '0;
`endif
        end else begin
            state    <= state_d;
            div_cnt  <= div_d;
            half_cnt <= half_d;
`ifdef IMU_CONT_EN
            gap_cnt  <= gap_d;
`endif
        end
    end

    // Next-state, counter and serial-clock decisions.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state;
        div_d     = div_cnt;
        half_d    = half_cnt;
        sclk_d    = imu_sclk;
        srclk_d   = sr_clk;
        in_shift  = 1'b0;
        out_shift = 1'b0;
`ifdef IMU_CONT_EN
        gap_d     = gap_cnt;
`endif
        case (state)
            ST_IDLE: if (en && start_edge) state_d = ST_READ;
            ST_READ: begin
                div_d = half_done ? '0 : div_cnt + DIV_W'(1);
                if (half_done) begin
                    sclk_d   = ~imu_sclk;
                    in_shift = ~imu_sclk;          // capture on the 0->1 toggle
                    half_d   = half_cnt + HALF_W'(1);
                    if (half_cnt == HALF_LAST) state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SHIFT;
            ST_SHIFT: begin
                div_d = half_done ? '0 : div_cnt + DIV_W'(1);
                if (half_done) begin
                    srclk_d   = ~sr_clk;
                    out_shift = sr_clk;            // advance bit after the high phase
                    half_d    = half_cnt + HALF_W'(1);
                    if (half_cnt == HALF_LAST) state_d = ST_LATCH;
                end
            end
            ST_LATCH:
`ifdef IMU_CONT_EN
                state_d = (enable_sync && en) ? ST_GAP : ST_IDLE;
            ST_GAP: begin
                gap_d = gap_cnt + GAP_W'(1);
                if (!enable_sync)            state_d = ST_IDLE;
                else if (gap_cnt == GAP_LAST) state_d = ST_READ;
            end
`else
                state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase

        // Losing the enable abandons the frame from any active state.
        if (state != ST_IDLE && !en) state_d = ST_IDLE;

        // Counters restart on every state entry; they never wrap on their own.
        if (state_d != state) begin
            div_d  = '0;
            half_d = '0;
`ifdef IMU_CONT_EN
            gap_d  = '0;
`endif
        end
        if (state_d != ST_READ)  sclk_d  = 1'b0;
        if (state_d != ST_SHIFT) srclk_d = 1'b0;
    end

    assign load_go = (state == ST_READ) && (state_d == ST_LOAD);
    assign sr_sdi  = out_shreg[DATA_W-1];

    // Registered pin outputs, sample capture and both data shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            imu_cs_n     <= 1'b1;
            imu_sclk     <= 1'b0;
            sr_clk       <= 1'b0;
            sr_latch     <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            in_shreg     <= '0;
            out_shreg    <= '0;
        end else begin
            imu_cs_n     <= (state_d != ST_READ);
            imu_sclk     <= sclk_d;
            sr_clk       <= srclk_d;
            sr_latch     <= (state_d == ST_LATCH);
            sample_valid <= load_go;
            busy         <= (state_d != ST_IDLE);
            if (in_shift) in_shreg <= {in_shreg[DATA_W-2:0], imu_sdo_in};
            if (load_go) begin
                sample    <= in_shreg;
                out_shreg <= in_shreg;
            end else if (out_shift) begin
                out_shreg <= {out_shreg[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_imu_seq_ctrl.sv
// tb_imu_seq_ctrl: scoreboard bench for imu_seq_ctrl. A behavioural IMU feeds
// queued words; monitors rebuild samples and the shift-register stream and
// compare them against the expected words queued by the stimulus.
`timescale 1ns/1ps
module tb_imu_seq_ctrl;

    localparam int DATA_W    = 16;
    localparam int CLK_DIV   = 2;
    localparam int GAP_CYC   = 100;
    localparam int READ_CYC  = 2 * DATA_W * CLK_DIV;          // chip-select low time
    localparam int FRAME_CYC = READ_CYC + 1 + READ_CYC + 1;   // READ+LOAD+SHIFT+LATCH

    logic              clk = 1'b0;
    logic              rst, en, imu_enable_in, imu_sdo_in;
    logic              imu_cs_n, imu_sclk, sr_sdi, sr_clk, sr_latch;
    logic [DATA_W-1:0] sample;
    logic              sample_valid, busy;

    imu_seq_ctrl #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .GAP(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .en(en), .imu_enable_in(imu_enable_in),
        .imu_sdo_in(imu_sdo_in), .imu_cs_n(imu_cs_n), .imu_sclk(imu_sclk),
        .sr_sdi(sr_sdi), .sr_clk(sr_clk), .sr_latch(sr_latch), .sample(sample),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard queues: words the IMU will send, expected samples, expected streams.
    logic [DATA_W-1:0] tx_q[$];
    logic [DATA_W-1:0] exp_sample_q[$];
    logic [DATA_W-1:0] exp_sr_q[$];
    int                cs_fall_q[$];

    // Behavioural IMU: MSB on chip-select fall, next bit on each sclk fall.
    logic [DATA_W-1:0] imu_word = '0;
    int                imu_bit = 0;
    logic              imu_cs_prev = 1'b1, imu_sclk_prev = 1'b0;
    always @(negedge clk) begin
        if (imu_cs_prev === 1'b1 && imu_cs_n === 1'b0) begin
            if (tx_q.size() > 0) imu_word = tx_q.pop_front();
            else                 imu_word = '0;
            imu_bit    = DATA_W - 1;
            imu_sdo_in = imu_word[imu_bit];
        end else if (imu_cs_n === 1'b0 && imu_sclk_prev === 1'b1 && imu_sclk === 1'b0 && imu_bit > 0) begin
            imu_bit    = imu_bit - 1;
            imu_sdo_in = imu_word[imu_bit];
        end
        imu_cs_prev   = imu_cs_n;
        imu_sclk_prev = imu_sclk;
    end

    // Sample monitor: every sample_valid pops one expected word.
    int valid_cnt = 0;
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            valid_cnt++;
            if (exp_sample_q.size() == 0) check("sample_unexpected", 32'd1, 32'd0);
            else                          check("sample_value", 32'(sample), 32'(exp_sample_q.pop_front()));
        end
    end

    // Shift-register monitor: collect sr_sdi on sr_clk rises, compare at the latch.
    logic [DATA_W-1:0] sr_acc = '0;
    int                sr_bits = 0, latch_cnt = 0;
    logic              sr_clk_prev = 1'b0;
    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            sr_acc  = '0;
            sr_bits = 0;
        end else begin
            if (sr_clk === 1'b1 && sr_clk_prev === 1'b0) begin
                sr_acc  = {sr_acc[DATA_W-2:0], sr_sdi};
                sr_bits++;
            end
            if (sr_latch === 1'b1) begin
                latch_cnt++;
                check("sr_bit_count", 32'(sr_bits), 32'(DATA_W));
                if (exp_sr_q.size() == 0) check("sr_unexpected", 32'd1, 32'd0);
                else                      check("sr_stream", 32'(sr_acc), 32'(exp_sr_q.pop_front()));
                sr_acc  = '0;
                sr_bits = 0;
            end
        end
        sr_clk_prev = sr_clk;
    end

    // Timing monitor: chip-select fall stamps and low/busy run lengths.
    int   cs_fall_cnt = 0, last_cs_fall = 0, cs_run = 0, last_cs_len = 0;
    int   busy_run = 0, last_busy_len = 0;
    logic tm_cs_prev = 1'b1;
    always @(negedge clk) begin
        if (tm_cs_prev === 1'b1 && imu_cs_n === 1'b0) begin
            cs_fall_cnt++;
            last_cs_fall = cyc;
            cs_fall_q.push_back(cyc);
        end
        if (imu_cs_n === 1'b0) cs_run++;
        else if (cs_run != 0) begin last_cs_len = cs_run; cs_run = 0; end
        if (busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin last_busy_len = busy_run; busy_run = 0; end
        tm_cs_prev = imu_cs_n;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    logic [DATA_W-1:0] exp_sample_reg = '0;

    task automatic start_pulse(input int n);
        imu_enable_in = 1'b1;
        repeat (n) @(negedge clk);
        imu_enable_in = 1'b0;
    endtask

    task automatic wait_frame_done(input int budget);
        int k = 0;
        while (busy !== 1'b1 && k < budget) begin @(negedge clk); k++; end
        while (busy === 1'b1 && k < budget) begin @(negedge clk); k++; end
        check("frame_done_in_time", 32'(k < budget), 32'd1);
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] w);
        tx_q.push_back(w);
        exp_sample_q.push_back(w);
        exp_sr_q.push_back(w);
        start_pulse(3);
        wait_frame_done(1000);
        repeat (2) @(negedge clk);
        exp_sample_reg = w;
        check("sample_held", 32'(sample), 32'(w));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},   32'(imu_cs_n),     32'd1);
        check({tag, "_sclk"},   32'(imu_sclk),     32'd0);
        check({tag, "_sr_sdi"}, 32'(sr_sdi),       32'd0);
        check({tag, "_sr_clk"}, 32'(sr_clk),       32'd0);
        check({tag, "_latch"},  32'(sr_latch),     32'd0);
        check({tag, "_sample"}, 32'(sample),       32'd0);
        check({tag, "_valid"},  32'(sample_valid), 32'd0);
        check({tag, "_busy"},   32'(busy),         32'd0);
    endtask

    int                t_raise, base_valid, base_latch, base_fall, k, rises;
    logic              prev;
    logic [DATA_W-1:0] w;

    initial begin
        rst = 1'b1; en = 1'b1; imu_enable_in = 1'b0; imu_sdo_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame with the reference word.
        base_valid = valid_cnt; base_latch = latch_cnt;
        tx_q.push_back(16'hA5C3); exp_sample_q.push_back(16'hA5C3); exp_sr_q.push_back(16'hA5C3);
        t_raise = cyc;
        start_pulse(3);
        wait_frame_done(1000);
        repeat (2) @(negedge clk);
        check("start_latency", 32'(last_cs_fall - t_raise), 32'd3);
        check("cs_low_cycles", 32'(last_cs_len), 32'(READ_CYC));
        check("busy_cycles",   32'(last_busy_len), 32'(FRAME_CYC));
        check("single_valids", 32'(valid_cnt - base_valid), 32'd1);
        check("single_latches", 32'(latch_cnt - base_latch), 32'd1);
        check("single_sample", 32'(sample), 32'hA5C3);
        exp_sample_reg = 16'hA5C3;

`ifndef IMU_CONT_EN
        // Level held high: one frame only.
        base_fall = cs_fall_cnt; base_valid = valid_cnt;
        w = DATA_W'($urandom);
        tx_q.push_back(w); exp_sample_q.push_back(w); exp_sr_q.push_back(w);
        imu_enable_in = 1'b1;
        repeat (15000) @(negedge clk);
        imu_enable_in = 1'b0;
        repeat (5) @(negedge clk);
        check("level_frames", 32'(cs_fall_cnt - base_fall), 32'd1);
        check("level_valids", 32'(valid_cnt - base_valid), 32'd1);
        exp_sample_reg = w;
`endif

        // A request pulse arriving during SHIFT is dropped.
        base_fall = cs_fall_cnt;
        w = DATA_W'($urandom);
        tx_q.push_back(w); exp_sample_q.push_back(w); exp_sr_q.push_back(w);
        start_pulse(3);
        k = 0;
        while (sr_clk !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        check("reach_shift", 32'(sr_clk), 32'd1);
        start_pulse(4);
        wait_frame_done(1000);
        repeat (20) @(negedge clk);
        check("shift_pulse_frames", 32'(cs_fall_cnt - base_fall), 32'd1);
        exp_sample_reg = w;

        // Abort after the 5th imu_sclk rise; start edges ignored while en=0.
        base_valid = valid_cnt; base_fall = cs_fall_cnt;
        tx_q.push_back(DATA_W'($urandom));
        start_pulse(3);
        k = 0; rises = 0; prev = imu_sclk;
        while (rises < 5 && k < 500) begin
            @(negedge clk); k++;
            if (imu_sclk === 1'b1 && prev === 1'b0) rises++;
            prev = imu_sclk;
        end
        check("abort_sclk_rises", 32'(rises), 32'd5);
        en = 1'b0;
        @(negedge clk);
        check("abort_cs_n", 32'(imu_cs_n), 32'd1);
        check("abort_sclk", 32'(imu_sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        start_pulse(3);
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (10) @(negedge clk);
        check("en_low_frames", 32'(cs_fall_cnt - base_fall), 32'd1);
        check("abort_no_valid", 32'(valid_cnt - base_valid), 32'd0);
        check("abort_sample_kept", 32'(sample), 32'(exp_sample_reg));

        // Reset after 8 bits have been shifted out.
        w = DATA_W'($urandom);
        tx_q.push_back(w); exp_sample_q.push_back(w);
        start_pulse(3);
        k = 0; rises = 0; prev = sr_clk;
        while (rises < 8 && k < 1000) begin
            @(negedge clk); k++;
            if (sr_clk === 1'b1 && prev === 1'b0) rises++;
            prev = sr_clk;
        end
        check("rst_sr_rises", 32'(rises), 32'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        exp_sample_reg = '0;
        run_frame(DATA_W'($urandom));

        // Data extremes and random words.
        run_frame('0);
        run_frame('1);
        for (int i = 0; i < 3; i++) run_frame(DATA_W'($urandom));

`ifdef IMU_CONT_EN
        // Continuous mode: three frames back-to-back, then release.
        base_fall = cs_fall_cnt; base_valid = valid_cnt;
        cs_fall_q.delete();
        for (int i = 0; i < 3; i++) begin
            w = DATA_W'($urandom);
            tx_q.push_back(w); exp_sample_q.push_back(w); exp_sr_q.push_back(w);
        end
        imu_enable_in = 1'b1;
        k = 0;
        while ((cs_fall_cnt - base_fall) < 3 && k < 2000) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        imu_enable_in = 1'b0;
        wait_frame_done(1000);
        repeat (20) @(negedge clk);
        check("cont_frames", 32'(cs_fall_cnt - base_fall), 32'd3);
        check("cont_valids", 32'(valid_cnt - base_valid), 32'd3);
        check("cont_fall_log", 32'(cs_fall_q.size()), 32'd3);
        if (cs_fall_q.size() >= 3) begin
            check("cont_spacing_1", 32'(cs_fall_q[1] - cs_fall_q[0]), 32'(FRAME_CYC + GAP_CYC));
            check("cont_spacing_2", 32'(cs_fall_q[2] - cs_fall_q[1]), 32'(FRAME_CYC + GAP_CYC));
        end
        check("cont_idle", 32'(busy), 32'd0);
`endif

        check("sample_q_drained", 32'(exp_sample_q.size()), 32'd0);
        check("sr_q_drained",     32'(exp_sr_q.size()),     32'd0);
        check("tx_q_drained",     32'(tx_q.size()),         32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
